// File: rtl/cla_serial_adder_ctrl.sv
// cla_serial_adder_ctrl: WIDTH-bit add/subtract computed one nibble per clock
// through a single shared 4-bit carry-lookahead adder, LSB nibble first, with
// the inter-nibble carry held in a register. Operands arrive on a valid/ready
// handshake; the result is held with o_DONE until the consumer acknowledges.

// 4-bit carry-lookahead adder: all carries derived directly from generate /
// propagate terms so the nibble add has no internal ripple.
module cla (
  input  logic [3:0] i_A,
  input  logic [3:0] i_B,
  input  logic       i_CIN,
  output logic [3:0] o_SUM,
  output logic       o_COUT
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign w_g[gi]   = i_A[gi] & i_B[gi];
    assign w_p[gi]   = i_A[gi] ^ i_B[gi];
    assign o_SUM[gi] = w_p[gi] ^ w_c[gi];
  end

  assign w_c[0] = i_CIN;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign o_COUT = w_c[4];
endmodule

module cla_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_VALID,
  output logic             o_READY,
  input  logic [WIDTH-1:0] i_INPUT_A,
  input  logic [WIDTH-1:0] i_INPUT_B,
  input  logic             i_CIN,
  input  logic             i_SUB,
  output logic             o_DONE,
  input  logic             i_ACK,
  output logic [WIDTH-1:0] o_RESULT,
  output logic             o_COUT,
  output logic             o_OVERFLOW
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int MSB     = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;       // B already inverted for subtract
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum;
  logic             w_cout;
  logic             w_last;

  assign w_a_nib = r_a[4*r_cnt +: 4];
  assign w_b_nib = r_b[4*r_cnt +: 4];
  assign w_last  = (r_cnt == CW'(NIBBLES - 1));

  // The one shared adder; its operands come only from registers, so there is
  // no combinational path from the request inputs to the result.
  cla u_cla (
    .i_A    (w_a_nib),
    .i_B    (w_b_nib),
    .i_CIN  (r_carry),
    .o_SUM  (w_sum),
    .o_COUT (w_cout)
  );

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    o_READY      = 1'b0;
    o_DONE       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_READY = 1'b1;
        if (i_VALID) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        o_DONE = 1'b1;
        if (i_ACK) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge i_CLK) begin
    if (i_RST) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Operand capture on accept, then one nibble per RUN cycle.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_VALID) begin
            r_a     <= i_INPUT_A;
            r_b     <= i_SUB ? ~i_INPUT_B : i_INPUT_B;
            r_carry <= i_SUB | i_CIN;   // subtract forces carry-in of 1
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_result[4*r_cnt +: 4] <= w_sum;
          r_carry                <= w_cout;
          r_cnt                  <= w_last ? '0 : r_cnt + CW'(1);
          // The MSB nibble is being written this edge, so use the adder's
          // sum bit directly rather than the not-yet-updated result register.
          if (w_last)
            r_overflow <= (r_a[MSB] == r_b[MSB]) && (w_sum[3] != r_a[MSB]);
        end
        default: ;
      endcase
    end
  end

  assign o_RESULT   = r_result;
  assign o_COUT     = r_carry;
  assign o_OVERFLOW = r_overflow;
endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Bench for cla_serial_adder_ctrl: directed cases plus a randomized sweep on a
// 16-bit and a 4-bit instance, checked against an arithmetic reference model.
module tb_cla_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst, vreq, ack, cin, sub, sel4;
  logic [15:0] a_in, b_in;

  logic        valid16, ack16, rdy16, done16, co16, ov16;
  logic [15:0] res16;
  logic        valid4, ack4, rdy4, done4, co4, ov4;
  logic [3:0]  res4;

  logic        mon_ready, mon_done, mon_cout, mon_ovf;
  logic [15:0] mon_res;

  int n_tests = 0;
  int n_fail  = 0;
  int acc16 = 0, dn16 = 0, acc4 = 0, dn4 = 0;
  logic pd16 = 1'b0, pd4 = 1'b0;

  always #5 clk = ~clk;

  // sel4 routes the shared control signals and monitors to one instance
  assign valid16 = vreq & ~sel4;
  assign ack16   = ack & ~sel4;
  assign valid4  = vreq & sel4;
  assign ack4    = ack & sel4;

  assign mon_ready = sel4 ? rdy4  : rdy16;
  assign mon_done  = sel4 ? done4 : done16;
  assign mon_cout  = sel4 ? co4   : co16;
  assign mon_ovf   = sel4 ? ov4   : ov16;
  assign mon_res   = sel4 ? {12'h000, res4} : res16;

  cla_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .i_CLK(clk), .i_RST(rst), .i_VALID(valid16), .o_READY(rdy16),
    .i_INPUT_A(a_in), .i_INPUT_B(b_in), .i_CIN(cin), .i_SUB(sub),
    .o_DONE(done16), .i_ACK(ack16), .o_RESULT(res16), .o_COUT(co16),
    .o_OVERFLOW(ov16)
  );

  cla_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .i_CLK(clk), .i_RST(rst), .i_VALID(valid4), .o_READY(rdy4),
    .i_INPUT_A(a_in[3:0]), .i_INPUT_B(b_in[3:0]), .i_CIN(cin), .i_SUB(sub),
    .o_DONE(done4), .i_ACK(ack4), .o_RESULT(res4), .o_COUT(co4),
    .o_OVERFLOW(ov4)
  );

  // Count accepts and o_DONE rising edges per instance.
  always @(posedge clk) begin
    if (!rst && valid16 && rdy16) acc16++;
    if (!rst && valid4 && rdy4)   acc4++;
    if (done16 && !pd16) dn16++;
    if (done4 && !pd4)   dn4++;
    pd16 = done16;
    pd4  = done4;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic ci, input logic sb,
                                output logic [15:0] r, output logic co, output logic ov);
    longint m, aa, bb, s, half, sa, sbv, rs;
    m    = (longint'(1) << w) - 1;
    aa   = longint'(a) & m;
    bb   = longint'(b) & m;
    half = longint'(1) << (w - 1);
    if (sb) begin
      s  = aa - bb;
      co = (aa >= bb);
    end else begin
      s  = aa + bb + longint'(ci);
      co = (s > m);
    end
    r   = 16'(s & m);
    sa  = (aa >= half) ? aa - (m + 1) : aa;
    sbv = (bb >= half) ? bb - (m + 1) : bb;
    rs  = sb ? (sa - sbv) : (sa + sbv + longint'(ci));
    ov  = (rs >= half) || (rs < -half);
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    int n = 0;
    @(negedge clk);
    a_in = a; b_in = b; cin = ci; sub = sb; vreq = 1'b1;
    while (!mon_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", 32'(mon_ready), 32'd1);
    @(posedge clk);
    #1 vreq = 1'b0;
  endtask

  task automatic wait_done(input int w);
    int n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!mon_done && n < 40);
    chk("latency_edges", 32'(n), 32'(w / 4));
  endtask

  task automatic check_result(input int w, input logic [15:0] a, input logic [15:0] b,
                              input logic ci, input logic sb);
    logic [15:0] r;
    logic co, ov;
    model(w, a, b, ci, sb, r, co, ov);
    chk("result", 32'(mon_res), 32'(r));
    chk("cout", 32'(mon_cout), 32'(co));
    chk("overflow", 32'(mon_ovf), 32'(ov));
  endtask

  task automatic finish_op(input int dly);
    logic [15:0] held;
    held = mon_res;
    for (int i = 0; i < dly; i++) begin
      @(posedge clk);
      #1;
      chk("hold_done", 32'(mon_done), 32'd1);
      chk("hold_result", 32'(mon_res), 32'(held));
    end
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    chk("ack_done", 32'(mon_done), 32'd0);
    chk("ack_ready", 32'(mon_ready), 32'd1);
  endtask

  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input int dly);
    start_op(a, b, ci, sb);
    wait_done(w);
    check_result(w, a, b, ci, sb);
    finish_op(dly);
  endtask

  initial begin
    logic [15:0] held;
    rst = 1'b1; vreq = 1'b0; ack = 1'b0; cin = 1'b0; sub = 1'b0; sel4 = 1'b0;
    a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of both instances
    chk("rst_ready16", 32'(rdy16), 32'd1);
    chk("rst_done16", 32'(done16), 32'd0);
    chk("rst_result16", 32'(res16), 32'd0);
    chk("rst_cout16", 32'(co16), 32'd0);
    chk("rst_ovf16", 32'(ov16), 32'd0);
    chk("rst_ready4", 32'(rdy4), 32'd1);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_result4", 32'(res4), 32'd0);

    // Directed 16-bit cases
    run_op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 2);
    run_op(16, 16'h0005, 16'h0007, 1'b1, 1'b1, 1);
    run_op(16, 16'h0007, 16'h0005, 1'b0, 1'b1, 0);
    run_op(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16, 16'h8000, 16'h0001, 1'b0, 1'b1, 0);

    // Backpressure: result held, no accept while DONE, new op after ack
    start_op(16'h1234, 16'h0FED, 1'b0, 1'b0);
    wait_done(16);
    check_result(16, 16'h1234, 16'h0FED, 1'b0, 1'b0);
    held = mon_res;
    @(negedge clk);
    a_in = 16'hAAAA; b_in = 16'h5555; cin = 1'b1; sub = 1'b0; vreq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", 32'(mon_ready), 32'd0);
      chk("bp_done", 32'(mon_done), 32'd1);
      chk("bp_result", 32'(mon_res), 32'(held));
    end
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    chk("bp_ack_ready", 32'(mon_ready), 32'd1);
    chk("bp_ack_done", 32'(mon_done), 32'd0);
    @(posedge clk);
    #1 vreq = 1'b0;
    chk("bp_accepted", 32'(mon_ready), 32'd0);
    wait_done(16);
    check_result(16, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
    finish_op(0);

    // Reset while the counter is at 2 aborts the operation
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_ready", 32'(mon_ready), 32'd1);
    chk("abort_done", 32'(mon_done), 32'd0);
    chk("abort_result", 32'(mon_res), 32'd0);
    run_op(16, 16'h1234, 16'h4321, 1'b0, 1'b0, 1);

    // Randomized sweep on both widths
    for (int s = 0; s < 2; s++) begin
      sel4 = (s == 1);
      for (int i = 0; i < 500; i++) begin
        logic [15:0] ra, rb;
        ra = 16'($urandom);
        rb = 16'($urandom);
        run_op(sel4 ? 4 : 16, ra, rb, 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("accepts_vs_dones16", 32'(dn16), 32'(acc16 - 1));
    chk("accepts_vs_dones4", 32'(dn4), 32'(acc4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
